apb_switch_bank: RTL and testbench

Parametrised APB3 slave that debounces NUM_SW active-low push-button/switch inputs and presents their levels, edge events and a shared fabric interrupt to the processor. It replaces the fixed two-switch, pulse-only interrupt block with:
- per-channel rising/falling-edge enables;
- sticky write-1-to-clear pending flags;
- a readable debounced-status register.

It sits on the fabric APB3 bus next to the other memory-mapped peripherals, and its INT output drives one FABINT line.

---
 rtl/apb_switch_bank.sv | 143 ++++++++++++++
 tb/tb_apb_switch_bank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_switch_bank.sv
// rtl/apb_switch_bank.sv - APB3 slave: debounced active-low switches, edge-enabled sticky interrupt
// Optional per-channel press counters at 0x40+4*i when SWBANK_PRESS_COUNT_EN is defined.
module apb_switch_bank #(
  parameter int NUM_SW  = 4,
  parameter int DB_BITS = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NUM_SW-1:0] SW,
  output logic              INT
);

  localparam logic [7:0] ADDR_STATUS  = 8'h00;
  localparam logic [7:0] ADDR_RISE_EN = 8'h04;
  localparam logic [7:0] ADDR_FALL_EN = 8'h08;
  localparam logic [7:0] ADDR_PENDING = 8'h0C;
  localparam logic [7:0] ADDR_RAW     = 8'h10;

  logic [7:0]        addr;
  logic              wr_en;
  logic [NUM_SW-1:0] sync_q1, sync_q2;
  logic [NUM_SW-1:0] level, level_d, armed, differ;
  logic [NUM_SW-1:0] rise_en, fall_en, pending;
  logic [NUM_SW-1:0] rise, fall, evt, w1c;
  logic [DB_BITS-1:0] db_cnt [NUM_SW];
  logic [31:0]       cnt_rdata;
  logic              unused_bits;

  assign addr        = PADDR[7:0];
  assign wr_en       = PSEL & PENABLE & PWRITE;
  assign unused_bits = ^{PADDR[31:8], PWDATA[31:NUM_SW]};
  assign PREADY      = 1'b1;
  assign PSLVERR     = 1'b0;

  // Inverted on capture so a pressed (low) switch reads as 1 from here on.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= ~SW;
      sync_q2 <= sync_q1;
    end
  end

  assign differ = sync_q2 ^ level;

  // armed holds off the first count so a change needs 2^DB_BITS full counted cycles
  // after it is first seen, putting the LEVEL toggle 2^DB_BITS+2 edges after capture.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      level <= '0;
      armed <= '0;
      for (int i = 0; i < NUM_SW; i++) db_cnt[i] <= '0;
    end else begin
      armed <= differ;
      for (int i = 0; i < NUM_SW; i++) begin
        if (!differ[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == {DB_BITS{1'b1}}) begin
          level[i]  <= ~level[i];
          db_cnt[i] <= '0;
        end else if (armed[i]) begin
          db_cnt[i] <= db_cnt[i] + DB_BITS'(1);
        end
      end
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;
  assign evt  = (rise & rise_en) | (fall & fall_en);
  assign w1c  = (wr_en && addr == ADDR_PENDING) ? PWDATA[NUM_SW-1:0] : '0;

  // New events are OR-ed in after the clear so a coincident set wins.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      level_d <= '0;
      rise_en <= '0;
      fall_en <= '0;
      pending <= '0;
    end else begin
      level_d <= level;
      if (wr_en && addr == ADDR_RISE_EN) rise_en <= PWDATA[NUM_SW-1:0];
      if (wr_en && addr == ADDR_FALL_EN) fall_en <= PWDATA[NUM_SW-1:0];
      pending <= (pending & ~w1c) | evt;
    end
  end

  assign INT = |pending;

`ifdef SWBANK_PRESS_COUNT_EN
  logic [7:0] press_cnt [NUM_SW];
  logic [3:0] cnt_idx;
  logic       cnt_sel;

  assign cnt_idx = addr[5:2];
  assign cnt_sel = (addr[7:6] == 2'b01) && (addr[1:0] == 2'b00) &&
                   ({1'b0, cnt_idx} < 5'(NUM_SW));

  // Counts every debounced press regardless of RISE_EN; a clear racing a press leaves 1.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_SW; i++) press_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SW; i++) begin
        if (wr_en && cnt_sel && cnt_idx == 4'(i)) begin
          press_cnt[i] <= {7'd0, rise[i]};
        end else if (rise[i]) begin
          press_cnt[i] <= press_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign cnt_rdata = cnt_sel ? {24'd0, press_cnt[cnt_idx]} : 32'd0;
`else
  assign cnt_rdata = 32'd0;
`endif

  always_comb begin
    PRDATA = 32'd0;
    if (PSEL) begin
      case (addr)
        ADDR_STATUS:  PRDATA = 32'(level);
        ADDR_RISE_EN: PRDATA = 32'(rise_en);
        ADDR_FALL_EN: PRDATA = 32'(fall_en);
        ADDR_PENDING: PRDATA = 32'(pending);
        ADDR_RAW:     PRDATA = 32'(sync_q2);
        default:      PRDATA = cnt_rdata;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_switch_bank.sv
// tb/tb_apb_switch_bank.sv - scoreboard bench for apb_switch_bank (NUM_SW=4, DB_BITS=4)
// Press-counter expectations follow SWBANK_PRESS_COUNT_EN.
module tb_apb_switch_bank;

  localparam int NUM_SW  = 4;
  localparam int DB_BITS = 4;

`ifdef SWBANK_PRESS_COUNT_EN
  localparam logic [31:0] CNT0_EXP = 32'd3;
  localparam logic [31:0] CNT3_EXP = 32'd1;
`else
  localparam logic [31:0] CNT0_EXP = 32'd0;
  localparam logic [31:0] CNT3_EXP = 32'd0;
`endif

  logic              PCLK = 1'b0;
  logic              PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0]       PADDR, PWDATA, PRDATA;
  logic              PREADY, PSLVERR;
  logic [NUM_SW-1:0] SW;
  logic              INT;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        early;
  string       exp_tag_q [$];
  logic [31:0] exp_val_q [$];

  always #5 PCLK = ~PCLK;

  apb_switch_bank #(.NUM_SW(NUM_SW), .DB_BITS(DB_BITS)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .SW(SW), .INT(INT)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {24'd0, a}; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, input string tag, input logic [31:0] expv);
    string       t;
    logic [31:0] e;
    exp_tag_q.push_back(tag);
    exp_val_q.push_back(expv);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = {24'd0, a};
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    t = exp_tag_q.pop_front();
    e = exp_val_q.pop_front();
    check_eq(t, PRDATA, e);
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic hold_cycles(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic press_release(input int ch);
    @(negedge PCLK);
    SW[ch] = 1'b0;
    hold_cycles(22);
    SW[ch] = 1'b1;
    hold_cycles(22);
  endtask

  initial begin
    logic [7:0] offs [7];
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h4C};
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; SW = '1; early = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // Reset state
    #1;
    check_eq("prdata_idle", PRDATA, 32'd0);
    check_eq("pready", {31'd0, PREADY}, 32'd1);
    check_eq("int_reset", {31'd0, INT}, 32'd0);
    foreach (offs[i]) apb_read(offs[i], $sformatf("reset_rd_%02h", offs[i]), 32'd0);

    // Press latency on channel 0: PENDING/INT exactly 19 edges after capture edge
    apb_write(8'h04, 32'h1);
    @(negedge PCLK);
    SW[0] = 1'b0;
    for (int n = 0; n <= 19; n++) begin
      @(posedge PCLK);
      #1;
      if (n < 18 && INT) early = 1'b1;
      if (n == 18) check_eq("int_edge18", {31'd0, INT}, 32'd0);
      if (n == 19) check_eq("int_edge19", {31'd0, INT}, 32'd1);
    end
    check_eq("int_not_early", {31'd0, early}, 32'd0);
    apb_read(8'h00, "status_ch0", 32'h1);
    apb_read(8'h10, "raw_ch0", 32'h1);
    apb_read(8'h0C, "pending_ch0", 32'h1);
    apb_write(8'h0C, 32'h1);
    check_eq("int_after_w1c", {31'd0, INT}, 32'd0);
    apb_read(8'h0C, "pending_w1c", 32'h0);

    // Release with FALL_EN=0: event lost
    @(negedge PCLK);
    SW[0] = 1'b1;
    hold_cycles(25);
    apb_read(8'h0C, "fall_disabled_lost", 32'h0);
    apb_read(8'h00, "status_released", 32'h0);

    // Glitches shorter than the debounce window
    apb_write(8'h04, 32'hF);
    apb_write(8'h08, 32'hF);
    @(negedge PCLK);
    SW[1] = 1'b0;
    hold_cycles(10);
    SW[1] = 1'b1;
    hold_cycles(25);
    apb_read(8'h0C, "glitch10_pending", 32'h0);
    apb_read(8'h00, "glitch10_status", 32'h0);
    @(negedge PCLK);
    SW[1] = 1'b0;
    hold_cycles(16);
    SW[1] = 1'b1;
    hold_cycles(25);
    apb_read(8'h0C, "glitch16_pending", 32'h0);
    check_eq("glitch_int", {31'd0, INT}, 32'd0);

    // Fall-only enable on channel 2
    apb_write(8'h04, 32'h0);
    apb_write(8'h08, 32'h4);
    @(negedge PCLK);
    SW[2] = 1'b0;
    hold_cycles(40);
    apb_read(8'h0C, "ch2_press_none", 32'h0);
    apb_read(8'h00, "ch2_status", 32'h4);
    SW[2] = 1'b1;
    hold_cycles(40);
    apb_read(8'h0C, "ch2_release_pend", 32'h4);
    check_eq("ch2_int", {31'd0, INT}, 32'd1);
    apb_write(8'h0C, 32'h4);
    check_eq("ch2_int_clr", {31'd0, INT}, 32'd0);

    // Clearing an enable keeps a pending bit
    apb_write(8'h04, 32'h1);
    apb_write(8'h08, 32'h0);
    @(negedge PCLK);
    SW[0] = 1'b0;
    hold_cycles(30);
    apb_write(8'h04, 32'h0);
    apb_read(8'h0C, "en_clear_keeps", 32'h1);
    apb_write(8'h04, 32'h1);
    SW[0] = 1'b1;
    hold_cycles(30);
    check_eq("int_before_race", {31'd0, INT}, 32'd1);

    // W1C lands on the same edge (k+19) as a new rise: set wins
    SW[0] = 1'b0;
    repeat (18) @(posedge PCLK);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0C; PWDATA = 32'h1;
    @(negedge PCLK);
    PENABLE = 1'b1;
    check_eq("int_access_phase", {31'd0, INT}, 32'd1);
    @(posedge PCLK);
    #1;
    check_eq("int_race", {31'd0, INT}, 32'd1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    apb_read(8'h0C, "race_set_wins", 32'h1);
    apb_write(8'h0C, 32'h1);
    @(negedge PCLK);
    SW[0] = 1'b1;
    hold_cycles(30);

    // Press counters (or unmapped offsets without the counter build)
    for (int p = 0; p < 257; p++) press_release(3);
    apb_read(8'h4C, "cnt3_257", CNT3_EXP);
    apb_read(8'h40, "cnt0", CNT0_EXP);
    apb_write(8'h4C, 32'h0);
    apb_read(8'h4C, "cnt3_clr", 32'h0);

    // Reset mid-debounce restarts the channel from released
    @(negedge PCLK);
    SW[3] = 1'b0;
    hold_cycles(10);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    apb_read(8'h00, "rst_mid_status", 32'h0);
    apb_read(8'h04, "rst_rise_en", 32'h0);
    check_eq("rst_int", {31'd0, INT}, 32'd0);
    hold_cycles(25);
    apb_read(8'h00, "rst_restart_status", 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
